// File: rtl/risc_controller_if.sv
// Control bundle between the phase-sequenced controller and the 8-bit datapath.
// The controller drives the strobes; the datapath supplies opcode, flags, ready.
interface risc_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       data_e;
    logic       wr;
    logic [2:0] alu_op;
    logic       halted;

    modport master (
        input  opcode, zero, mem_ready,
        output sel, rd, ld_ir, inc_pc, ld_pc,
        output ld_ac, data_e, wr, alu_op, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  sel, rd, ld_ir, inc_pc, ld_pc,
        input  ld_ac, data_e, wr, alu_op, halted
    );
endinterface

// File: rtl/risc_controller.sv
// Eight-phase control unit for the accumulator CPU: phase register, halt flop,
// and a combinational strobe decode of phase, opcode and the zero flag.
module risc_controller #(
    parameter bit USE_READY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    risc_controller_if.master bus
);
    typedef enum logic [2:0] {
        INST_ADDR,
        INST_FETCH,
        INST_LOAD,
        IDLE,
        OP_ADDR,
        OP_FETCH,
        ALU_OP,
        STORE
    } phase_t;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;
    localparam logic [2:0] AND = 3'b100;
    localparam logic [2:0] OR  = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    phase_t     phase;
    phase_t     phase_next;
    logic       halted;
    logic       halted_next;
    logic       is_alu;
    logic       stall;
    logic [2:0] phase_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            phase  <= phase_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.data_e = 1'b0;
        bus.wr     = 1'b0;
        bus.alu_op = 3'b000;
        is_alu     = 1'b0;
        unique case (bus.opcode)
            ADD:     is_alu = 1'b1;
            SUB:     is_alu = 1'b1;
            AND:     is_alu = 1'b1;
            OR:      is_alu = 1'b1;
            default: is_alu = 1'b0;
        endcase
        unique case (phase)
            INST_ADDR: bus.sel = 1'b1;
            INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
            end
            OP_ADDR: bus.inc_pc = 1'b1;
            OP_FETCH: bus.rd = is_alu;
            ALU_OP: begin
                bus.rd     = is_alu;
                bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
                bus.ld_pc  = (bus.opcode == JMP);
                bus.data_e = (bus.opcode == STO);
            end
            STORE: begin
                bus.rd     = is_alu;
                bus.ld_ac  = is_alu;
                bus.ld_pc  = (bus.opcode == JMP);
                bus.data_e = (bus.opcode == STO);
                bus.wr     = (bus.opcode == STO);
            end
            default: bus.sel = 1'b1;
        endcase
        if (phase >= OP_FETCH) begin
            unique case (1'b1)
                bus.opcode == SUB: bus.alu_op = 3'b001;
                bus.opcode == AND: bus.alu_op = 3'b010;
                bus.opcode == OR:  bus.alu_op = 3'b011;
                default:           bus.alu_op = 3'b000;
            endcase
        end
    end

    // Only the two read phases can be stretched, and only while rd is high.
    assign stall = USE_READY && !bus.mem_ready && bus.rd &&
                   (phase == INST_FETCH || phase == OP_FETCH);
    assign phase_inc = phase + 3'd1;
    assign bus.halted = halted;

    always_comb begin
        phase_next  = phase;
        halted_next = halted;
        if (!halted && !stall) begin
            phase_next = phase_t'(phase_inc);
            if (phase == OP_ADDR && bus.opcode == HLT)
                halted_next = 1'b1;
        end
    end
endmodule
